reg_serializer: RTL and testbench
=================================

Name: reg_serializer

Overview:
- Unload stage for the datapath register library: takes a parallel DATAWIDTH word (typically a REG output) and shifts it out one bit per accepted transfer.
- Valid/ready handshake on both sides. It is the reading/transmitting end of a registered word, used where a generated datapath drives a narrow serial sink.
- Holds one word at a time. Enforces one idle cycle between words.

Parameters:
- DATAWIDTH, 8, width of the parallel input word; legal range 1..64.
- MSB_FIRST, 1, 1 means bit DATAWIDTH-1 is sent first; 0 means bit 0 is sent first.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-low reset.
- d  input  DATAWIDTH  parallel word to serialize.
- d_valid  input  1  d is valid this cycle.
- d_ready  output  1  block can accept a word this cycle.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout is valid.
- sout_ready  input  1  sink accepts sout this cycle.
- sout_last  output  1  current bit is the final bit of the word.
- busy  output  1  a word is being shifted (state SHIFT).

Behaviour:
- Clock and reset: one clock, Clk. Rst is asynchronous and active-low. While Rst=0:
  - state=IDLE; shift register, bit counter, sout, sout_valid, sout_last and busy are all 0.
  - d_ready=0. It is gated by Rst, so it is low during reset and 1 from the first cycle after release.
- States: IDLE and SHIFT (2-bit encoding reserved; unused codes go to IDLE).
- IDLE:
  - d_ready=1, sout_valid=0, busy=0.
  - On d_valid=1 at an edge: capture d into the shift register, load counter=DATAWIDTH-1, go to SHIFT.
  - d_valid with d_ready=0 is ignored; the source must hold it.
- SHIFT:
  - d_ready=0, busy=1, sout_valid=1.
  - sout = shreg[DATAWIDTH-1] if MSB_FIRST, else shreg[0].
  - sout_last = (counter==0).
  - Transfer happens on an edge with sout_valid=1 and sout_ready=1:
    - If counter!=0: shift the register toward the output end (zero fill), counter decrements.
    - If counter==0: go to IDLE.
- Outputs are registered or decoded from state/shreg/counter only. There is no combinational path from sout_ready or d_valid to any output.
- Latency, no stalls:
  - Word accepted at edge t; first bit valid in cycle t+1.
  - Last bit transfers at edge t+DATAWIDTH.
  - d_ready returns high in cycle t+DATAWIDTH+1.
  - Throughput: one word per DATAWIDTH+1 cycles.
- Backpressure: while sout_ready=0, sout, sout_valid, sout_last and the counter hold unchanged for any number of cycles.
- Counter width: max(1, clog2(DATAWIDTH)).
- DATAWIDTH=1: counter loads 0, sout_last=1 on the only bit, one transfer returns to IDLE.
- d changing while in SHIFT: no effect; the word was captured at acceptance.
- Reset asserted mid-word: immediate abort to IDLE, remaining bits discarded, sout_valid drops asynchronously.
- No wrap-around: the counter never decrements below 0, because 0 with a transfer exits SHIFT.

Decomposition:
- Shared package holds the state encodings (ST_IDLE=2'b00, ST_SHIFT=2'b01) and a CLOG2 constant function reused by other library components.
- Single module; the counter and shift register are inline. No sub-module is warranted at this size.

Test Plan:
- Reset then idle: hold Rst=0 for 3 cycles, then release. Required: d_ready=0 during reset and 1 after release; sout_valid=0, busy=0.
- MSB-first word, DATAWIDTH=8, MSB_FIRST=1, d=8'hA5, sout_ready=1 throughout. Required:
  - sout sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles.
  - sout_last=1 only on the 8th bit.
  - d_ready high again on the 9th cycle after acceptance.
- LSB-first with stalls: MSB_FIRST=0, d=8'h01, sout_ready toggling 1,0,1,0. Required:
  - sout sequence 1,0,0,0,0,0,0,0.
  - Bits and sout_last hold unchanged on every stall cycle.
  - 16 cycles to complete.
- Back-to-back words: d_valid held high with 8'hFF then 8'h00. Required: second word accepted only after the first word's last transfer plus one IDLE cycle; sout shows eight 1s, a gap, then eight 0s.
- Mid-word reset: after 3 bits of 8'hF0, assert Rst=0. Required: sout_valid=0 immediately; after release, a new word 8'h0F serializes cleanly with no leftover bits.
- DATAWIDTH=1 build: d=1'b1. Required: a single transfer with sout=1 and sout_last=1, and d_ready high 2 cycles after acceptance.

Source files
------------

// File: rtl/reg_serializer_pkg.sv
// Shared definitions for the datapath register library: serializer state codes
// and a constant-foldable ceiling-log2 helper.
package reg_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01
  } state_t;

  // Number of bits needed to index v distinct values (0 for v <= 1)
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/reg_serializer.sv
// Parallel-to-serial unload stage: captures one word on a valid/ready handshake
// and shifts it out one bit per accepted serial transfer.
module reg_serializer
  import reg_serializer_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATAWIDTH-1:0] d,
  input  logic                 d_valid,
  output logic                 d_ready,
  output logic                 sout,
  output logic                 sout_valid,
  input  logic                 sout_ready,
  output logic                 sout_last,
  output logic                 busy
);

  localparam int unsigned CW = (clog2(DATAWIDTH) > 0) ? clog2(DATAWIDTH) : 1;

  state_t               state;
  logic [DATAWIDTH-1:0] shreg;
  logic [CW-1:0]        cnt;

  // Capture on acceptance, shift toward the output end on each transfer
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= ST_IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (d_valid) begin
            shreg <= d;
            cnt   <= CW'(DATAWIDTH - 1);
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (sout_ready) begin
            if (cnt == '0) begin
              state <= ST_IDLE;
            end else begin
              shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
              cnt   <= cnt - CW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode only from state/shreg/cnt; d_ready is additionally held low in reset
  assign d_ready    = Rst & (state == ST_IDLE);
  assign busy       = (state == ST_SHIFT);
  assign sout_valid = busy;
  assign sout       = MSB_FIRST ? shreg[DATAWIDTH-1] : shreg[0];
  assign sout_last  = busy & (cnt == '0);

endmodule

// File: tb/tb_reg_serializer.sv
// Scoreboarded bench for reg_serializer: three builds (8/MSB, 8/LSB, 1/MSB)
// checked against a queue-of-bits reference model.
module tb_reg_serializer;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  int          dw  [3] = '{8, 8, 1};
  bit          msb [3] = '{1'b1, 1'b0, 1'b1};
  logic [63:0] din [3];
  logic [2:0]  dv = '0;
  logic [2:0]  sr = '1;
  wire  [2:0]  dr, so, sv, sl, bz;
  int          sr_mode [3];

  int errors = 0;
  int checks = 0;

  // Expected serial stream per build: {bit, last}
  logic [1:0] expq [3][$];

  reg_serializer #(.DATAWIDTH(8), .MSB_FIRST(1'b1)) u_msb8 (
    .Clk(Clk), .Rst(Rst), .d(din[0][7:0]), .d_valid(dv[0]), .d_ready(dr[0]),
    .sout(so[0]), .sout_valid(sv[0]), .sout_ready(sr[0]), .sout_last(sl[0]), .busy(bz[0]));

  reg_serializer #(.DATAWIDTH(8), .MSB_FIRST(1'b0)) u_lsb8 (
    .Clk(Clk), .Rst(Rst), .d(din[1][7:0]), .d_valid(dv[1]), .d_ready(dr[1]),
    .sout(so[1]), .sout_valid(sv[1]), .sout_ready(sr[1]), .sout_last(sl[1]), .busy(bz[1]));

  reg_serializer #(.DATAWIDTH(1), .MSB_FIRST(1'b1)) u_w1 (
    .Clk(Clk), .Rst(Rst), .d(din[2][0:0]), .d_valid(dv[2]), .d_ready(dr[2]),
    .sout(so[2]), .sout_valid(sv[2]), .sout_ready(sr[2]), .sout_last(sl[2]), .busy(bz[2]));

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %b expected %b at %0t", name, idx, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT against the model every cycle, pops on transfer, pushes on acceptance
  bit         idle;
  logic [1:0] f;
  int         b;
  always @(negedge Clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!Rst) begin
        expq[i].delete();
        chk("rst_d_ready", i, dr[i], 1'b0);
        chk("rst_sout_valid", i, sv[i], 1'b0);
        chk("rst_busy", i, bz[i], 1'b0);
      end else begin
        idle = (expq[i].size() == 0);
        chk("d_ready", i, dr[i], idle);
        chk("busy", i, bz[i], !idle);
        chk("sout_valid", i, sv[i], !idle);
        if (!idle) begin
          f = expq[i][0];
          chk("sout", i, so[i], f[1]);
          chk("sout_last", i, sl[i], f[0]);
          if (sr[i]) void'(expq[i].pop_front());
        end else if (dv[i]) begin
          for (int k = 0; k < dw[i]; k++) begin
            b = msb[i] ? (dw[i] - 1 - k) : k;
            expq[i].push_back({din[i][b], (k == dw[i] - 1)});
          end
        end
      end
    end
  end

  // Sink readiness per build: 0 always ready, 1 toggling, 2 random
  always @(posedge Clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      case (sr_mode[i])
        0:       sr[i] = 1'b1;
        1:       sr[i] = ~sr[i];
        default: sr[i] = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Present a word, hold d_valid until accepted, then scramble d to show it is ignored
  task automatic send(input int i, input logic [63:0] w);
    int n;
    n = 0;
    din[i] = w;
    dv[i]  = 1'b1;
    do begin
      @(negedge Clk);
      n++;
    end while (!dr[i] && n < 500);
    chk("accept", i, dr[i], 1'b1);
    @(posedge Clk);
    #1;
    dv[i]  = 1'b0;
    din[i] = {$urandom, $urandom};
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (expq[i].size() != 0 && n < 1000) begin
      @(negedge Clk);
      n++;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic rand_words(input int i);
    repeat (20) begin
      repeat ($urandom_range(0, 3)) @(posedge Clk);
      @(posedge Clk);
      #1;
      send(i, {$urandom, $urandom});
    end
    wait_idle(i);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      din[i]     = '0;
      sr_mode[i] = 0;
    end
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b1;
    @(posedge Clk);
    #1;

    // Directed words: MSB-first A5, LSB-first 01 with stalls, single-bit build
    sr_mode[1] = 1;
    fork
      send(0, 64'hA5);
      send(1, 64'h01);
      send(2, 64'h1);
    join
    for (int i = 0; i < 3; i++) wait_idle(i);
    sr_mode[1] = 0;

    // Back-to-back with d_valid effectively held high
    send(0, 64'hFF);
    send(0, 64'h00);
    wait_idle(0);

    // Mid-word reset after three bits of F0, then a clean 0F
    send(0, 64'hF0);
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;
    #1;
    chk("abort_sout_valid", 0, sv[0], 1'b0);
    chk("abort_busy", 0, bz[0], 1'b0);
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b1;
    send(0, 64'h0F);
    wait_idle(0);

    // Randomized traffic with random backpressure on all builds
    for (int i = 0; i < 3; i++) sr_mode[i] = 2;
    fork
      rand_words(0);
      rand_words(1);
      rand_words(2);
    join

    repeat (5) @(posedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
